input_tokenizer: RTL and testbench

//  Streams raw ASCII puzzle input from a byte ROM and parses it into unsigned decimal tokens.

---
 rtl/input_tokenizer_pkg.sv | 15 +
 rtl/input_tokenizer.sv | 152 +++++++++++++++
 tb/tb_input_tokenizer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/input_tokenizer_pkg.sv
// input_tokenizer_pkg: ASCII constants, FSM states and token record for input_tokenizer.
package input_tokenizer_pkg;
  localparam logic [7:0] ASCII_NL = 8'h0A;
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_9 = 8'h39;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam int TOK_W = 64;
  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_RUN, S_EMIT, S_FLUSH, S_DONE} tok_state_t;
  typedef struct packed {
    logic [TOK_W-1:0] value;
    logic eol;
    logic blank;
    logic last;
  } token_t;
endpackage

// File: rtl/input_tokenizer.sv
// input_tokenizer: parses ROM bytes into decimal tokens over valid/ready; NUM_W up to 64.
// Define SIGNED_TOKENS_EN to let a '-' directly before a digit negate the token.
module input_tokenizer
  import input_tokenizer_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int INPUT_LEN = 1024,
  parameter int NUM_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              tok_valid,
  input  logic              tok_ready,
  output logic [NUM_W-1:0]  tok_value,
  output logic              tok_eol,
  output logic              tok_blank,
  output logic              tok_last,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(INPUT_LEN - 1);
  tok_state_t state, nstate;
  logic [ADDR_W-1:0] cnt;
  logic [NUM_W-1:0] acc, acc_nx, num_val;
  logic in_num, prev_nl, eoi, pend_v, skid_v;
  logic [7:0] skid, b;
  token_t pend, tok;
  logic is_dig, is_nl, blank_ev, num_start, emit, at_last;
`ifdef SIGNED_TOKENS_EN
  logic neg, minus;
`endif
  // A finished token waits in pend until the next token starts or input ends,
  // so the final one can carry tok_last even when separators trail it.
  always_comb begin
    b = skid_v ? skid : rom_data;
    is_dig = b >= ASCII_0 && b <= ASCII_9;
    is_nl = b == ASCII_NL;
    at_last = cnt == LAST;
    blank_ev = is_nl && !in_num && prev_nl;
    num_start = is_dig && !in_num;
    emit = pend_v && (num_start || blank_ev);
    acc_nx = acc * NUM_W'(10) + NUM_W'(b - ASCII_0);
`ifdef SIGNED_TOKENS_EN
    num_val = neg ? -acc : acc;
`else
    num_val = acc;
`endif
    unique case (state)
      S_IDLE, S_DONE: nstate = start ? S_PRIME : state;
      S_PRIME: nstate = S_RUN;
      S_RUN: nstate = emit ? S_EMIT : at_last ? S_FLUSH : S_RUN;
      S_EMIT: nstate = !tok_ready ? S_EMIT : tok.last ? S_DONE : eoi ? S_FLUSH : S_RUN;
      S_FLUSH: nstate = (in_num || pend_v) ? S_EMIT : S_DONE;
      default: nstate = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      rom_addr <= '0;
      cnt <= '0;
      acc <= '0;
      in_num <= 1'b0;
      prev_nl <= 1'b0;
      eoi <= 1'b0;
      pend <= '0;
      pend_v <= 1'b0;
      tok <= '0;
      skid <= '0;
      skid_v <= 1'b0;
      done <= 1'b0;
`ifdef SIGNED_TOKENS_EN
      neg <= 1'b0;
      minus <= 1'b0;
`endif
    end else begin
      state <= nstate;
      case (state)
        S_IDLE, S_DONE: if (start) begin
          rom_addr <= '0;
          cnt <= '0;
          acc <= '0;
          in_num <= 1'b0;
          prev_nl <= 1'b1;
          eoi <= 1'b0;
          pend_v <= 1'b0;
          skid_v <= 1'b0;
          done <= 1'b0;
`ifdef SIGNED_TOKENS_EN
          neg <= 1'b0;
          minus <= 1'b0;
`endif
        end
        S_PRIME: rom_addr <= (rom_addr == LAST) ? rom_addr : rom_addr + 1'b1;
        S_RUN: begin
          skid_v <= 1'b0;
          prev_nl <= is_nl;
          eoi <= at_last;
          if (!at_last) cnt <= cnt + 1'b1;
          if (!emit && rom_addr != LAST) rom_addr <= rom_addr + 1'b1;
          if (emit) tok <= pend;
`ifdef SIGNED_TOKENS_EN
          minus <= b == ASCII_MINUS;
          if (num_start) neg <= minus;
`endif
          if (is_dig) begin
            acc <= acc_nx;
            in_num <= 1'b1;
          end else if (in_num) begin
            pend <= '{value: TOK_W'(num_val), eol: is_nl, blank: 1'b0, last: 1'b0};
            pend_v <= 1'b1;
            acc <= '0;
            in_num <= 1'b0;
          end else if (blank_ev) begin
            pend <= '{value: '0, eol: 1'b1, blank: 1'b1, last: 1'b0};
            pend_v <= 1'b1;
          end
          if (num_start) pend_v <= 1'b0;
        end
        // Address was held on entry, so rom_data is the next byte until we leave.
        S_EMIT: begin
          if (!skid_v) begin
            skid <= rom_data;
            skid_v <= 1'b1;
          end
          if (tok_ready) begin
            if (tok.last) done <= 1'b1;
            else if (!eoi && rom_addr != LAST) rom_addr <= rom_addr + 1'b1;
          end
        end
        S_FLUSH: begin
          if (in_num) tok <= '{value: TOK_W'(num_val), eol: 1'b0, blank: 1'b0, last: 1'b1};
          else if (pend_v) tok <= '{value: pend.value, eol: pend.eol, blank: pend.blank, last: 1'b1};
          else done <= 1'b1;
          in_num <= 1'b0;
          pend_v <= 1'b0;
          acc <= '0;
        end
        default: ;
      endcase
    end
  end
  assign tok_valid = state == S_EMIT;
  assign tok_value = NUM_W'(tok.value);
  assign tok_eol = tok.eol;
  assign tok_blank = tok.blank;
  assign tok_last = tok.last;
  assign busy = state inside {S_PRIME, S_RUN, S_EMIT, S_FLUSH};
endmodule

// File: tb/tb_input_tokenizer.sv
// tb_input_tokenizer: table vectors, reset/stall sequences and random ROMs against a lexical model.
module tb_input_tokenizer;
  localparam int N = 32;
`ifdef SIGNED_TOKENS_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, tok_ready = 1'b0;
  logic [7:0] rom_addr, rom_data;
  logic tok_valid, tok_eol, tok_blank, tok_last, busy, done;
  logic [63:0] tok_value;
  logic [7:0] mem [N];
  int checks = 0, failures = 0;
  int rmode = 0, cyc = 0, last_hs = -1, done_cyc = -1, stalls = 0, stab_err = 0, max_addr = 0;
  bit busy_at_done = 1'b0, prev_stall = 1'b0;
  logic [66:0] held = '0;
  string got = "";

  typedef struct {logic [63:0] v; bit e; bit b;} tk_t;
  typedef struct {string name; string rom; int mode; bit restart; string exp;} vec_t;
  vec_t tbl[$];

  input_tokenizer #(.ADDR_W(8), .INPUT_LEN(N), .NUM_W(64)) dut (
    .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_value(tok_value), .tok_eol(tok_eol),
    .tok_blank(tok_blank), .tok_last(tok_last), .busy(busy), .done(done)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) rom_data <= mem[rom_addr[4:0]];

  initial forever begin
    @(posedge clk);
    #1;
    case (rmode)
      0: tok_ready = 1'b1;
      1: tok_ready = ~tok_ready;
      2: tok_ready = stalls >= 5;
      default: tok_ready = 1'($urandom_range(0, 1));
    endcase
  end

  function automatic string fmt(logic [63:0] v, bit e, bit bl, bit l);
    string r;
    r = $sformatf("%0d", $signed(v));
    if (e) r = {r, "e"};
    if (bl) r = {r, "b"};
    if (l) r = {r, "L"};
    return r;
  endfunction

  initial forever begin
    @(negedge clk);
    cyc++;
    if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
    if (tok_valid && (done || (prev_stall && held != {tok_value, tok_eol, tok_blank, tok_last}))) stab_err++;
    if (tok_valid && !tok_ready) stalls++;
    if (tok_valid && tok_ready) begin
      if (got.len() > 0) got = {got, " "};
      got = {got, fmt(tok_value, tok_eol, tok_blank, tok_last)};
      last_hs = cyc;
    end
    if (done && done_cyc < 0) begin
      done_cyc = cyc;
      busy_at_done = busy;
    end
    prev_stall = tok_valid && !tok_ready;
    held = {tok_value, tok_eol, tok_blank, tok_last};
  end

  // Tokens are maximal digit runs; a newline at byte 0 or after a newline is a blank token.
  function automatic string model();
    tk_t q[$];
    logic [63:0] v = '0;
    logic [7:0] c;
    bit in = 1'b0, neg = 1'b0;
    string r = "";
    for (int i = 0; i < N; i++) begin
      c = mem[i];
      if (c >= 8'h30 && c <= 8'h39) begin
        if (!in) begin
          v = '0;
          neg = SGN && i > 0 && mem[i-1] == 8'h2D;
          in = 1'b1;
        end
        v = v * 64'd10 + 64'(c - 8'h30);
      end else begin
        if (in) q.push_back('{neg ? -v : v, c == 8'h0A, 1'b0});
        in = 1'b0;
        if (c == 8'h0A && (i == 0 || mem[i-1] == 8'h0A)) q.push_back('{64'd0, 1'b1, 1'b1});
      end
    end
    if (in) q.push_back('{neg ? -v : v, 1'b0, 1'b0});
    foreach (q[k]) begin
      if (k > 0) r = {r, " "};
      r = {r, fmt(q[k].v, q[k].e, q[k].b, k == q.size() - 1)};
    end
    return r;
  endfunction

  function automatic string cap(string s);
    return s.len() > 200 ? s.substr(0, 199) : s;
  endfunction

  task automatic chk(input string nm, input bit ok, input string act, input string req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got '%s' expected '%s'", nm, cap(act), cap(req));
    end
  endtask

  task automatic load(input string s);
    for (int i = 0; i < N; i++) mem[i] = (i < s.len()) ? s[i] : 8'h20;
  endtask

  task automatic run(input string nm, input string exp, input int mode, input bit restart);
    int t;
    rmode = mode;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    got = "";
    last_hs = -1;
    done_cyc = -1;
    stalls = 0;
    stab_err = 0;
    max_addr = 0;
    prev_stall = 1'b0;
    @(negedge clk);
    chk({nm, " start"}, !done && busy, $sformatf("done=%0b busy=%0b", done, busy), "done=0 busy=1");
    if (restart) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    t = 0;
    while (!done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({nm, " timeout"}, done, $sformatf("done=%0b", done), "done=1");
    repeat (3) @(negedge clk);
    chk({nm, " tokens"}, got == exp, got, exp);
    chk({nm, " done_timing"}, (exp == "" ? done_cyc >= 0 : done_cyc == last_hs + 1) && !busy_at_done,
        $sformatf("done_cyc=%0d busy=%0b", done_cyc, busy_at_done), $sformatf("done_cyc=%0d busy=0", last_hs + 1));
    chk({nm, " stable"}, stab_err == 0, $sformatf("%0d", stab_err), "0");
    chk({nm, " addr_max"}, max_addr == N - 1, $sformatf("%0d", max_addr), $sformatf("%0d", N - 1));
    if (mode == 2) chk({nm, " stall"}, stalls == 5, $sformatf("%0d", stalls), "5");
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {tok_valid, tok_eol, tok_blank, tok_last, busy, done} == 6'b0 && tok_value == 64'd0 && rom_addr == 8'd0,
        $sformatf("v=%0b e=%0b b=%0b l=%0b busy=%0b done=%0b val=%0d addr=%0d",
                  tok_valid, tok_eol, tok_blank, tok_last, busy, done, tok_value, rom_addr), "all zero");
  endtask

  initial begin
    int m;
    tbl.push_back('{"two_lines", "12 34\n5\n", 0, 1'b0, "12 34e 5eL"});
    tbl.push_back('{"blank_line", "7\n\n8\n", 0, 1'b0, "7e 0eb 8eL"});
    tbl.push_back('{"hold_low", "123", 2, 1'b0, "123L"});
    tbl.push_back('{"toggle_ready", "1 2 3 4", 1, 1'b1, "1 2 3 4L"});
    tbl.push_back('{"wrap", "18446744073709551616", 0, 1'b0, "0L"});
    tbl.push_back('{"lead_nl", "\n5", 1, 1'b0, "0eb 5L"});
    tbl.push_back('{"two_blanks", "\n\n", 0, 1'b0, "0eb 0ebL"});
    tbl.push_back('{"no_tokens", ", ,\n", 0, 1'b0, ""});
`ifdef SIGNED_TOKENS_EN
    tbl.push_back('{"minus", "-3 4", 1, 1'b0, "-3 4L"});
`else
    tbl.push_back('{"minus", "-3 4", 1, 1'b0, "3 4L"});
`endif
    load("");
    repeat (2) @(posedge clk);
    #1 chk_zero("reset_state");
    reset = 1'b1;
    foreach (tbl[k]) begin
      load(tbl[k].rom);
      run(tbl[k].name, tbl[k].exp, tbl[k].mode, tbl[k].restart);
    end
    load("12345678901234567");
    rmode = 0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #2 reset = 1'b0;
    #1 chk_zero("mid_reset");
    @(posedge clk);
    #1 reset = 1'b1;
    load("9\n");
    run("after_reset", "9eL", 0, 1'b0);
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 15))
          9, 10, 11: mem[i] = 8'h20;
          12, 13: mem[i] = 8'h0A;
          14: mem[i] = 8'h2D;
          15: mem[i] = 8'h2C;
          default: mem[i] = 8'h30 + 8'($urandom_range(0, 9));
        endcase
      end
      m = $urandom_range(0, 2);
      run($sformatf("rand%0d", r), model(), m == 2 ? 3 : m, 1'b0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
